// File: rtl/tm1637_pkg.sv
// Shared op codes, TM1637 command bytes and state encodings for the
// display frame sequencer and its command issuer.
package tm1637_pkg;

    typedef enum logic [1:0] {
        OP_START = 2'd0,
        OP_BYTE  = 2'd1,
        OP_STOP  = 2'd2
    } op_e;

    localparam logic [7:0] CMD_DATA_AUTOINC = 8'h40;
    localparam logic [7:0] CMD_ADDR0        = 8'hC0;
    localparam logic [7:0] CMD_DISP_BASE    = 8'h80;

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_P1_START   = 4'd1,
        S_P1_CMD     = 4'd2,
        S_P1_STOP    = 4'd3,
        S_P2_START   = 4'd4,
        S_P2_ADDR    = 4'd5,
        S_P2_DIGIT   = 4'd6,
        S_P2_STOP    = 4'd7,
        S_P3_START   = 4'd8,
        S_P3_CTRL    = 4'd9,
        S_P3_STOP    = 4'd10,
        S_ABORT_STOP = 4'd11,
        S_DONE       = 4'd12
    } state_e;

    typedef enum logic [1:0] {
        PH_IDLE  = 2'd0,
        PH_ISSUE = 2'd1,
        PH_WAIT  = 2'd2
    } phase_e;

    function automatic op_e op_for_state(input state_e st);
        case (st)
            S_P1_START, S_P2_START, S_P3_START:         op_for_state = OP_START;
            S_P1_CMD, S_P2_ADDR, S_P2_DIGIT, S_P3_CTRL: op_for_state = OP_BYTE;
            default:                                    op_for_state = OP_STOP;
        endcase
    endfunction

    function automatic logic is_op_state(input state_e st);
        is_op_state = (st != S_IDLE) && (st != S_DONE);
    endfunction

endpackage

// File: rtl/tm1637_cmd_issuer.sv
// Runs the ISSUE/WAIT handshake for one engine operation and watches for a
// missing completion; reports ok, nack or timeout as single-cycle pulses.
module tm1637_cmd_issuer
    import tm1637_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4095
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       launch_i,
    input  op_e        launch_op_i,
    input  logic [7:0] launch_byte_i,
    output logic       cmd_valid_o,
    output op_e        cmd_op_o,
    output logic [7:0] cmd_byte_o,
    input  logic       cmd_ready_i,
    input  logic       cmd_done_i,
    input  logic       cmd_nack_i,
    output logic       res_ok_o,
    output logic       res_nack_o,
    output logic       res_timeout_o
);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

    phase_e        phase_q, phase_d;
    logic          valid_q, valid_d;
    op_e           op_q, op_d;
    logic [7:0]    byte_q, byte_d;
    logic          is_byte_q, is_byte_d;
    logic [WW-1:0] wdog_q, wdog_d;

    // Handshake phases, watchdog and result decode; a new launch always wins.
    always_comb begin
        phase_d       = phase_q;
        valid_d       = valid_q;
        op_d          = op_q;
        byte_d        = byte_q;
        is_byte_d     = is_byte_q;
        wdog_d        = wdog_q;
        res_ok_o      = 1'b0;
        res_nack_o    = 1'b0;
        res_timeout_o = 1'b0;
        case (phase_q)
            PH_ISSUE: begin
                if (cmd_ready_i) begin
                    phase_d = PH_WAIT;
                    valid_d = 1'b0;
                    op_d    = OP_START;
                    byte_d  = 8'h00;
                    wdog_d  = {WW{1'b0}};
                end else begin
                    valid_d = 1'b1;
                end
            end
            PH_WAIT: begin
                // A completion arriving on the threshold cycle still counts.
                if (cmd_done_i) begin
                    phase_d = PH_IDLE;
                    if (is_byte_q && cmd_nack_i) begin
                        res_nack_o = 1'b1;
                    end else begin
                        res_ok_o = 1'b1;
                    end
                end else if (wdog_q == WW'(TIMEOUT_CYCLES - 1)) begin
                    phase_d       = PH_IDLE;
                    res_timeout_o = 1'b1;
                end else begin
                    wdog_d = wdog_q + WW'(1);
                end
            end
            default: phase_d = PH_IDLE;
        endcase
        if (launch_i) begin
            phase_d   = PH_ISSUE;
            valid_d   = 1'b1;
            op_d      = launch_op_i;
            byte_d    = launch_byte_i;
            is_byte_d = (launch_op_i == OP_BYTE);
        end else begin
            is_byte_d = is_byte_d;
        end
    end

    // Phase, command output and watchdog registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q   <= PH_IDLE;
            valid_q   <= 1'b0;
            op_q      <= OP_START;
            byte_q    <= 8'h00;
            is_byte_q <= 1'b0;
            wdog_q    <= {WW{1'b0}};
        end else begin
            phase_q   <= phase_d;
            valid_q   <= valid_d;
            op_q      <= op_d;
            byte_q    <= byte_d;
            is_byte_q <= is_byte_d;
            wdog_q    <= wdog_d;
        end
    end

    assign cmd_valid_o = valid_q;
    assign cmd_op_o    = op_q;
    assign cmd_byte_o  = byte_q;

endmodule

// File: rtl/tm1637_frame_sequencer.sv
// Sequences one TM1637 refresh (data mode, address + digits, display control)
// as START/BYTE/STOP ops, with one coalescing pending update slot.
module tm1637_frame_sequencer
    import tm1637_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int TIMEOUT_CYCLES = 4095
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    upd_req,
    input  logic [8*NUM_DIGITS-1:0] upd_digits,
    input  logic [2:0]              upd_bright,
    input  logic                    upd_on,
    output logic                    upd_busy,
    output logic                    upd_done,
    output logic                    upd_err,
    output logic                    cmd_valid,
    output logic [1:0]              cmd_op,
    output logic [7:0]              cmd_byte,
    input  logic                    cmd_ready,
    input  logic                    cmd_done,
    input  logic                    cmd_nack,
    output logic [3:0]              dbg_state
);
    localparam int IW = $clog2(NUM_DIGITS + 1);

    state_e                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [8*NUM_DIGITS-1:0] dig_q, dig_d, pdig_q, pdig_d;
    logic [2:0]              bright_q, bright_d, pbright_q, pbright_d;
    logic                    on_q, on_d, pon_q, pon_d;
    logic                    pend_q, pend_d;
    logic                    err_q, err_d;
    logic                    busy_q, done_q;
    logic                    go_s, launch_s;
    op_e                     launch_op_s, cmd_op_s;
    logic [7:0]              launch_byte_s;
    logic                    res_ok_s, res_nack_s, res_timeout_s;

    // Frame FSM: request capture, op sequencing, abort handling and pending slot.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        dig_d     = dig_q;
        bright_d  = bright_q;
        on_d      = on_q;
        pend_d    = pend_q;
        pdig_d    = pdig_q;
        pbright_d = pbright_q;
        pon_d     = pon_q;
        err_d     = err_q;
        go_s      = 1'b0;
        if (upd_req && (state_q != S_IDLE) && (state_q != S_DONE)) begin
            pend_d    = 1'b1;
            pdig_d    = upd_digits;
            pbright_d = upd_bright;
            pon_d     = upd_on;
        end else begin
            pend_d = pend_d;
        end
        case (state_q)
            S_IDLE: begin
                if (upd_req) begin
                    dig_d    = upd_digits;
                    bright_d = upd_bright;
                    on_d     = upd_on;
                    err_d    = 1'b0;
                    state_d  = S_P1_START;
                    go_s     = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DONE: begin
                // A request in this very cycle is newer than the pending slot.
                pend_d = 1'b0;
                if (upd_req) begin
                    dig_d    = upd_digits;
                    bright_d = upd_bright;
                    on_d     = upd_on;
                    err_d    = 1'b0;
                    state_d  = S_P1_START;
                    go_s     = 1'b1;
                end else if (pend_q) begin
                    dig_d    = pdig_q;
                    bright_d = pbright_q;
                    on_d     = pon_q;
                    err_d    = 1'b0;
                    state_d  = S_P1_START;
                    go_s     = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                if (res_timeout_s) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (res_nack_s) begin
                    err_d   = 1'b1;
                    state_d = S_ABORT_STOP;
                    go_s    = 1'b1;
                end else if (res_ok_s) begin
                    go_s = 1'b1;
                    case (state_q)
                        S_P1_START: state_d = S_P1_CMD;
                        S_P1_CMD:   state_d = S_P1_STOP;
                        S_P1_STOP:  state_d = S_P2_START;
                        S_P2_START: state_d = S_P2_ADDR;
                        S_P2_ADDR: begin
                            state_d = S_P2_DIGIT;
                            idx_d   = {IW{1'b0}};
                        end
                        S_P2_DIGIT: begin
                            if (idx_q == IW'(NUM_DIGITS - 1)) begin
                                state_d = S_P2_STOP;
                            end else begin
                                idx_d = idx_q + IW'(1);
                            end
                        end
                        S_P2_STOP:    state_d = S_P3_START;
                        S_P3_START:   state_d = S_P3_CTRL;
                        S_P3_CTRL:    state_d = S_P3_STOP;
                        S_P3_STOP:    state_d = S_DONE;
                        S_ABORT_STOP: state_d = S_DONE;
                        default:      state_d = S_IDLE;
                    endcase
                end else begin
                    state_d = state_q;
                end
            end
        endcase
    end

    // Op and byte handed to the issuer when entering (or re-entering) an op state.
    always_comb begin
        launch_s    = go_s && is_op_state(state_d);
        launch_op_s = op_for_state(state_d);
        case (state_d)
            S_P1_CMD:   launch_byte_s = CMD_DATA_AUTOINC;
            S_P2_ADDR:  launch_byte_s = CMD_ADDR0;
            S_P2_DIGIT: launch_byte_s = 8'(dig_q >> {idx_d, 3'b000});
            S_P3_CTRL:  launch_byte_s = CMD_DISP_BASE | {4'b0000, on_q, bright_q};
            default:    launch_byte_s = 8'h00;
        endcase
    end

    // State, working/pending data and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= {IW{1'b0}};
            dig_q     <= {(8*NUM_DIGITS){1'b0}};
            bright_q  <= 3'd0;
            on_q      <= 1'b0;
            pend_q    <= 1'b0;
            pdig_q    <= {(8*NUM_DIGITS){1'b0}};
            pbright_q <= 3'd0;
            pon_q     <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            dig_q     <= dig_d;
            bright_q  <= bright_d;
            on_q      <= on_d;
            pend_q    <= pend_d;
            pdig_q    <= pdig_d;
            pbright_q <= pbright_d;
            pon_q     <= pon_d;
            err_q     <= err_d;
            busy_q    <= (state_d != S_IDLE);
            done_q    <= (state_d == S_DONE);
        end
    end

    tm1637_cmd_issuer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_issuer (
        .clk           (clk),
        .rst           (rst),
        .launch_i      (launch_s),
        .launch_op_i   (launch_op_s),
        .launch_byte_i (launch_byte_s),
        .cmd_valid_o   (cmd_valid),
        .cmd_op_o      (cmd_op_s),
        .cmd_byte_o    (cmd_byte),
        .cmd_ready_i   (cmd_ready),
        .cmd_done_i    (cmd_done),
        .cmd_nack_i    (cmd_nack),
        .res_ok_o      (res_ok_s),
        .res_nack_o    (res_nack_s),
        .res_timeout_o (res_timeout_s)
    );

    assign cmd_op    = cmd_op_s;
    assign upd_busy  = busy_q;
    assign upd_done  = done_q;
    assign upd_err   = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_tm1637_frame_sequencer.sv
// Scoreboard bench: expected engine ops are queued when a request is driven
// and compared as the engine model accepts them.
module tb_tm1637_frame_sequencer;
    localparam int ND = 4;
    localparam int TO = 16;

    localparam logic [1:0] T_START = 2'd0;
    localparam logic [1:0] T_BYTE  = 2'd1;
    localparam logic [1:0] T_STOP  = 2'd2;

    logic            clk = 1'b0;
    logic            rst;
    logic            upd_req;
    logic [8*ND-1:0] upd_digits;
    logic [2:0]      upd_bright;
    logic            upd_on;
    logic            upd_busy, upd_done, upd_err;
    logic            cmd_valid;
    logic [1:0]      cmd_op;
    logic [7:0]      cmd_byte;
    logic            cmd_ready, cmd_done, cmd_nack;
    logic [3:0]      dbg_state;

    logic            nack_en, withhold_40;
    logic [7:0]      nack_byte;
    logic [9:0]      exp_q[$];
    int              n_checks = 0;
    int              n_errors = 0;
    int              done_cnt = 0;

    tm1637_frame_sequencer #(.NUM_DIGITS(ND), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .upd_req(upd_req), .upd_digits(upd_digits),
        .upd_bright(upd_bright), .upd_on(upd_on), .upd_busy(upd_busy),
        .upd_done(upd_done), .upd_err(upd_err), .cmd_valid(cmd_valid),
        .cmd_op(cmd_op), .cmd_byte(cmd_byte), .cmd_ready(cmd_ready),
        .cmd_done(cmd_done), .cmd_nack(cmd_nack), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic push_op(input logic [1:0] op, input logic [7:0] b);
        exp_q.push_back({op, b});
    endtask

    task automatic push_frame(input logic [8*ND-1:0] d, input logic [2:0] br, input logic on);
        push_op(T_START, 8'h00); push_op(T_BYTE, 8'h40); push_op(T_STOP, 8'h00);
        push_op(T_START, 8'h00); push_op(T_BYTE, 8'hC0);
        for (int i = 0; i < ND; i++) push_op(T_BYTE, d[8*i +: 8]);
        push_op(T_STOP, 8'h00);
        push_op(T_START, 8'h00); push_op(T_BYTE, {4'b1000, on, br}); push_op(T_STOP, 8'h00);
    endtask

    task automatic req(input logic [8*ND-1:0] d, input logic [2:0] br, input logic on);
        @(posedge clk); #1;
        upd_req = 1'b1; upd_digits = d; upd_bright = br; upd_on = on;
        @(posedge clk); #1;
        upd_req = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!upd_done && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, 32'(upd_done), 32'd1);
    endtask

    task automatic run_frame(input string tag, input logic [8*ND-1:0] d, input logic [2:0] br, input logic on);
        int d0;
        d0 = done_cnt;
        push_frame(d, br, on);
        req(d, br, on);
        @(negedge clk);
        check({tag, "_valid_lat"}, 32'(cmd_valid), 32'd1);
        check({tag, "_busy_lat"}, 32'(upd_busy), 32'd1);
        wait_done(tag);
        check({tag, "_err"}, 32'(upd_err), 32'd0);
        @(negedge clk);
        check({tag, "_busy_after"}, 32'(upd_busy), 32'd0);
        check({tag, "_idle_after"}, 32'(dbg_state), 32'd0);
        check({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
        check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Engine model: accepts ops, scores them, completes each 3 cycles later.
    initial begin : engine
        int         cnt;
        logic       nk;
        logic [9:0] got;
        cnt = 0; nk = 1'b0;
        cmd_done = 1'b0; cmd_nack = 1'b0;
        forever begin
            @(negedge clk);
            cmd_done = 1'b0; cmd_nack = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    cmd_done = 1'b1;
                    cmd_nack = nk;
                end
            end
            if (cmd_valid && cmd_ready) begin
                got = {cmd_op, cmd_byte};
                if (exp_q.size() == 0) check("op_extra", 32'(got), 32'h3FF);
                else check("op_seq", 32'(got), 32'(exp_q.pop_front()));
                nk  = nack_en && (cmd_op == T_BYTE) && (cmd_byte == nack_byte);
                cnt = (withhold_40 && cmd_op == T_BYTE && cmd_byte == 8'h40) ? 0 : 3;
            end
        end
    end

    // Counts upd_done pulses.
    initial begin : done_mon
        forever begin
            @(negedge clk);
            if (upd_done) done_cnt++;
        end
    end

    initial begin : main
        int   d0, n;
        logic stable, any_valid, any_busy;
        rst = 1'b1; upd_req = 1'b0; upd_digits = '0; upd_bright = 3'd0; upd_on = 1'b0;
        cmd_ready = 1'b1; nack_en = 1'b0; nack_byte = 8'h00; withhold_40 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(cmd_valid), 32'd0);
        check("rst_busy", 32'(upd_busy), 32'd0);
        check("rst_done", 32'(upd_done), 32'd0);
        check("rst_err", 32'(upd_err), 32'd0);
        check("rst_dbg", 32'(dbg_state), 32'd0);
        check("rst_op_byte", 32'({cmd_op, cmd_byte}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_frame("normal", 32'h4F5B063F, 3'd7, 1'b1);
        run_frame("dispoff", 32'h4F5B063F, 3'd2, 1'b0);

        // NACK on digit1 aborts with a STOP.
        nack_en = 1'b1; nack_byte = 8'h06;
        push_op(T_START, 8'h00); push_op(T_BYTE, 8'h40); push_op(T_STOP, 8'h00);
        push_op(T_START, 8'h00); push_op(T_BYTE, 8'hC0); push_op(T_BYTE, 8'h3F);
        push_op(T_BYTE, 8'h06); push_op(T_STOP, 8'h00);
        req(32'h4F5B063F, 3'd7, 1'b1);
        wait_done("nack");
        check("nack_err", 32'(upd_err), 32'd1);
        repeat (3) @(negedge clk);
        check("nack_err_sticky", 32'(upd_err), 32'd1);
        check("nack_idle", 32'(upd_busy), 32'd0);
        check("nack_sb_empty", 32'(exp_q.size()), 32'd0);
        nack_en = 1'b0;

        // Coalescing: B is overwritten by C while frame A runs.
        d0 = done_cnt;
        push_frame(32'hA4A3A2A1, 3'd5, 1'b1);
        req(32'hA4A3A2A1, 3'd5, 1'b1);
        @(negedge clk);
        check("coal_err_cleared", 32'(upd_err), 32'd0);
        repeat (5) @(posedge clk);
        req(32'hB4B3B2B1, 3'd1, 1'b0);
        repeat (5) @(posedge clk);
        req(32'hC4C3C2C1, 3'd3, 1'b1);
        push_frame(32'hC4C3C2C1, 3'd3, 1'b1);
        wait_done("coalA");
        @(negedge clk);
        check("coal_no_idle_busy", 32'(upd_busy), 32'd1);
        check("coal_restart_state", 32'(dbg_state), 32'd1);
        check("coal_restart_valid", 32'(cmd_valid), 32'd1);
        wait_done("coalC");
        @(negedge clk);
        check("coal_busy_after", 32'(upd_busy), 32'd0);
        check("coal_done_pulses", 32'(done_cnt - d0), 32'd2);
        check("coal_sb_empty", 32'(exp_q.size()), 32'd0);

        // Backpressure: first op held while cmd_ready is low.
        @(posedge clk); #1;
        cmd_ready = 1'b0;
        push_frame(32'h66554433, 3'd4, 1'b1);
        req(32'h66554433, 3'd4, 1'b1);
        stable = 1'b1;
        repeat (5) begin
            @(negedge clk);
            stable = stable && cmd_valid && (cmd_op == T_START) && (cmd_byte == 8'h00);
        end
        check("bp_stable", 32'(stable), 32'd1);
        @(posedge clk); #1;
        cmd_ready = 1'b1;
        wait_done("bp");
        check("bp_err", 32'(upd_err), 32'd0);
        check("bp_sb_empty", 32'(exp_q.size()), 32'd0);

        // Timeout: completion withheld after 0x40; DONE after TO wait cycles.
        withhold_40 = 1'b1;
        push_op(T_START, 8'h00); push_op(T_BYTE, 8'h40);
        req(32'h4F5B063F, 3'd7, 1'b1);
        n = 0;
        @(negedge clk);
        while (!(cmd_valid && cmd_ready && cmd_op == T_BYTE) && n < 100) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        @(negedge clk);
        n++;
        while (!upd_done && n < 100) begin
            @(negedge clk);
            n++;
        end
        // The handshake cycle is followed by TO wait cycles, then DONE.
        check("to_latency", 32'(n), 32'(TO + 1));
        check("to_err", 32'(upd_err), 32'd1);
        @(negedge clk);
        check("to_busy_after", 32'(upd_busy), 32'd0);
        check("to_sb_empty", 32'(exp_q.size()), 32'd0);
        withhold_40 = 1'b0;

        // Reset in the middle of the digit bytes with an update pending.
        push_frame(32'h4F5B063F, 3'd7, 1'b1);
        req(32'h4F5B063F, 3'd7, 1'b1);
        n = 0;
        @(negedge clk);
        while (dbg_state != 4'd6 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rstmid_reached_digit", 32'(dbg_state), 32'd6);
        req(32'h77777777, 3'd6, 1'b1);
        rst = 1'b1;
        d0 = done_cnt;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("rstmid_valid", 32'(cmd_valid), 32'd0);
        check("rstmid_busy", 32'(upd_busy), 32'd0);
        check("rstmid_dbg", 32'(dbg_state), 32'd0);
        any_valid = 1'b0; any_busy = 1'b0;
        repeat (40) begin
            @(negedge clk);
            any_valid = any_valid | cmd_valid;
            any_busy  = any_busy | upd_busy;
        end
        check("rstmid_no_restart_valid", 32'(any_valid), 32'd0);
        check("rstmid_no_restart_busy", 32'(any_busy), 32'd0);
        check("rstmid_no_done", 32'(done_cnt - d0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : guard
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

endmodule
